// File: rtl/scandoubler.sv
// Line-doubling scan converter: each 15 kHz input line goes into one half of a
// ping-pong buffer and is read back twice from the other half at the 14 MHz rate.
module scandoubler #(
  parameter int unsigned RGBW  = 18,
  parameter int unsigned HBITS = 9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ice,
  input  logic            ihs,
  input  logic            ivs,
  input  logic [RGBW-1:0] irgb,
  input  logic            oce,
  output logic            ohs,
  output logic            ovs,
  output logic [RGBW-1:0] orgb
);

  localparam int unsigned AW = HBITS + 1;

  logic [RGBW-1:0]  mem [2**AW];

  logic             ihs_d;
  logic             bank;
  logic             obank;
  logic             locked;
  logic             ivs_sync;
  logic [1:0]       lines;
  logic [HBITS-1:0] hcnt;
  logic [HBITS-1:0] hlen;
  logic [HBITS-1:0] hsw;
  logic [HBITS-1:0] hswl;
  logic [HBITS-1:0] ocnt;

  logic             rise;
  logic             fall;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [HBITS-1:0] hlen_m1;

  assign rise    = ihs & ~ihs_d;
  assign fall    = ~ihs & ihs_d;
  // First pixel of a new line lands at address 0 of the bank about to become active
  assign waddr   = rise ? {~bank, HBITS'(0)} : {bank, hcnt};
  assign raddr   = {~bank, ocnt};
  // Clamp so a zero-length line cannot underflow the wrap compare
  assign hlen_m1 = (hlen == '0) ? '0 : hlen - HBITS'(1);

  // Line buffer write port
  always_ff @(posedge clock) begin
    if (ice) mem[waddr] <= irgb;
  end

  // Input side: line measurement, bank flip, lock tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ihs_d    <= 1'b0;
      bank     <= 1'b0;
      hcnt     <= '0;
      hlen     <= '0;
      hsw      <= '0;
      hswl     <= '0;
      lines    <= 2'd0;
      locked   <= 1'b0;
      ivs_sync <= 1'b0;
    end else if (ice) begin
      ihs_d    <= ihs;
      ivs_sync <= ivs;
      if (lines == 2'd2) locked <= 1'b1;
      if (rise) begin
        hlen <= hcnt;
        bank <= ~bank;
        hcnt <= HBITS'(1);
        hsw  <= HBITS'(1);
        if (lines != 2'd2) lines <= lines + 2'd1;
      end else begin
        if (hcnt != '1) hcnt <= hcnt + HBITS'(1);
        if (ihs && hsw != '1) hsw <= hsw + HBITS'(1);
      end
      if (fall) hswl <= hsw;
    end
  end

  // Output side: double-rate readout, realigned on every bank flip
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      obank <= 1'b0;
      ocnt  <= '0;
      ohs   <= 1'b0;
      ovs   <= 1'b0;
      orgb  <= '0;
    end else if (oce) begin
      obank <= bank;
      if (bank != obank)       ocnt <= '0;
      else if (ocnt == hlen_m1) ocnt <= '0;
      else                     ocnt <= ocnt + HBITS'(1);
      orgb <= locked ? mem[raddr] : '0;
      ohs  <= locked && (ocnt < (hswl >> 1));
      if (ocnt == '0) ovs <= locked ? ivs_sync : 1'b0;
    end
  end

endmodule

// File: doc/scandoubler.md
Name: scandoubler

Overview:
- Converts the 15 kHz ZX video stream into a 31 kHz stream for VGA monitors.
- Input is the post-OSD RGB with hsync/vsync, sampled on the 7 MHz pixel enable.
- Each input line is written into one half of a ping-pong line buffer while the other half is read out twice at the 14 MHz enable.
- Sits between the OSD overlay and the board video pins (sync/rgb).

Parameters:
- RGBW, 18, pixel width in bits (6:6:6).
- HBITS, 9, line buffer address width; supports lines up to 2**HBITS pixels (448-pixel ZX line fits).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- ice  input  1  input pixel enable (7 MHz, one-cycle strobe)
- ihs  input  1  input hsync, active high
- ivs  input  1  input vsync, active high
- irgb  input  RGBW  input pixel
- oce  input  1  output pixel enable (14 MHz, one-cycle strobe; exactly 2 per ice period)
- ohs  output  1  output hsync, active high
- ovs  output  1  output vsync, active high
- orgb  output  RGBW  output pixel

Behaviour:
- Reset (reset=0, async): ohs=0, ovs=0, orgb=0, all counters 0, bank=0, locked=0, hlen=0, hsw=0.

Input side, all updates gated by ice:
- ihs_d holds the previous ihs. A rising edge is ihs=1 && ihs_d=0.
- On a rising edge:
  - hlen <= hcnt (pixels in the completed line);
  - bank toggles;
  - hcnt <= 1;
  - the current pixel is written to address 0 of the new bank;
  - lines counter increments, saturating at 2.
- Otherwise, irgb is written to buffer[bank][hcnt] and hcnt increments, saturating at 2**HBITS-1. Writes at saturation overwrite the last cell.
- hsw measures input sync width: it counts ice strobes while ihs=1, clears on the rising edge, and its value is latched into hswl on the falling edge.
- locked <= 1 once lines reaches 2. It returns to 0 only on reset.

Output side, all updates gated by oce:
- ocnt increments. It wraps to 0 when ocnt == hlen-1, giving two output lines per input line.
- A bank toggle seen since the last oce forces ocnt <= 0. This realigns the output line start to the input line start.
- Read address is {~bank, ocnt}, i.e. the bank not being written.
- orgb <= buffer data when locked, else 0. Registered, so orgb lags ocnt by one oce.
- ohs <= locked && (ocnt < (hswl >> 1)). Output sync width is half the input sync width in ice units.
- ovs <= locked ? ivs_sync : 0. ovs is updated only when ocnt == 0, so it changes only at output line starts.
- Latency: an input line appears at the output starting with the first oce after the next ihs rising edge, i.e. one input line of delay. It is shown twice.

Edge cases:
- Simultaneous ice and oce in one clock: both sides act independently. A same-cycle bank toggle applies to the read on the next oce.
- The buffer is a true dual-port RAM, one write port and one read port, inferred on clock.
- hlen=0 or hlen=1 with locked=1: ocnt stays 0 and no wrap arithmetic underflow is allowed. Compare using hlen-1 computed with hlen forced to at least 1.
- Reset mid-line: all state clears. The output is dark and sync-less until two new ihs rising edges have been seen.

Test Plan:
- Reset held, random inputs toggling -> ohs=0, ovs=0, orgb=0 throughout. Release, then first ihs edge -> outputs still 0. Second ihs edge -> locked=1.
- 448-pixel lines, ihs high 32 ice wide, irgb=pixel index -> each output line is 448 oce long and ohs is 16 oce wide. Two output lines per input line, both carry values 0..447 in order, delayed one input line.
- ivs asserted mid input line -> ovs rises only at the next ocnt==0 oce. It falls likewise at an output line boundary.
- Input line length changed from 448 to 440 on one line -> next output pair wraps at 440. ocnt realigns to 0 at each ihs edge with no stray extra line.
- Input line of 600 pixels (exceeds 512) -> hcnt saturates at 511 and hlen=511. No address wrap corrupts cells 0..510.
- Reset asserted asynchronously between clock edges during active video -> outputs 0 immediately. Relock after two ihs edges following release.
